// File: rtl/ram32x4_arbiter.sv
// Round-robin arbiter giving two requesters shared use of one single-port synchronous RAM.
// After reset or a clr pulse, it first sweeps every word to CLR_VAL before serving requests.
//
// state   | meaning
// S_CLEAR | sweeping ptr over every word with CLR_VAL; busy, no grants
// S_SERVE | arbitrating A/B round-robin, one RAM access per cycle
module ram32x4_arbiter #(
    parameter int                ADDR_W  = 5,
    parameter int                DATA_W  = 4,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clr,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic {S_CLEAR, S_SERVE} state_t;

    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'((1 << ADDR_W) - 1);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   ptr;
    logic              last_b;
    logic              rd_pend_a, rd_pend_b;
    logic [DATA_W-1:0] hold_a, hold_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_CLEAR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (ptr == LAST_PTR) state_nxt = S_SERVE;
            S_SERVE: if (clr)             state_nxt = S_CLEAR;
            default:                      state_nxt = S_CLEAR;
        endcase
    end

    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        busy      = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            S_CLEAR: begin
                busy      = 1'b1;
                ram_we    = reset;
                ram_addr  = ptr[ADDR_W-1:0];
                ram_wdata = CLR_VAL;
            end
            S_SERVE: begin
                // On a tie, the side that was not served last wins.
                gnt_a = req_a & (~req_b | last_b);
                gnt_b = req_b & (~req_a | ~last_b);
                if (gnt_a) begin
                    ram_we    = we_a;
                    ram_addr  = addr_a;
                    ram_wdata = wdata_a;
                end else if (gnt_b) begin
                    ram_we    = we_b;
                    ram_addr  = addr_b;
                    ram_wdata = wdata_b;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            last_b    <= 1'b1;
            rd_pend_a <= 1'b0;
            rd_pend_b <= 1'b0;
            hold_a    <= '0;
            hold_b    <= '0;
        end else begin
            ptr       <= (state == S_CLEAR) ? ptr + (ADDR_W + 1)'(1) : '0;
            if (gnt_a)      last_b <= 1'b0;
            else if (gnt_b) last_b <= 1'b1;
            rd_pend_a <= gnt_a & ~we_a;
            rd_pend_b <= gnt_b & ~we_b;
            if (rd_pend_a) hold_a <= ram_rdata;
            if (rd_pend_b) hold_b <= ram_rdata;
        end
    end

    // Read data comes straight from the RAM in the rvalid cycle and is held afterwards.
    assign rvalid_a = rd_pend_a;
    assign rvalid_b = rd_pend_b;
    assign rdata_a  = rd_pend_a ? ram_rdata : hold_a;
    assign rdata_b  = rd_pend_b ? ram_rdata : hold_b;

endmodule

// File: tb/tb_ram32x4_arbiter.sv
// Bench for ram32x4_arbiter: a behavioural RAM, a word-level reference model checked every
// cycle, and directed scenarios with literal expectations.
module tb_ram32x4_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, we_a, req_b, we_b, clr;
    logic [4:0] addr_a, addr_b;
    logic [3:0] wdata_a, wdata_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_we;
    logic [3:0] rdata_a, rdata_b, ram_wdata, ram_rdata;
    logic [4:0] ram_addr;

    int errors = 0;
    int checks = 0;

    ram32x4_arbiter dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .clr(clr), .busy(busy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM seen by the DUT.
    logic [3:0] ram [0:31];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    // Reference model: remaining sweep words, round-robin memory, expected memory contents,
    // and one pending read per side carrying the word value seen at grant time.
    int         clear_left;
    bit         m_last_b;
    bit         m_pend_a, m_pend_b;
    logic [3:0] m_pend_data_a, m_pend_data_b, m_hold_a, m_hold_b;
    logic [3:0] model_mem [0:31];
    wire  [1:0] m_g;

    function automatic logic [1:0] winner(input bit serve, input logic ra, input logic rb,
                                          input bit lb);
        if (!serve) return 2'b00;
        if (ra && rb) return lb ? 2'b01 : 2'b10;
        return {rb, ra};
    endfunction

    assign m_g = winner(clear_left == 0, req_a, req_b, m_last_b);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            clear_left <= 32;
            m_last_b   <= 1'b1;
            m_pend_a   <= 1'b0;
            m_pend_b   <= 1'b0;
            m_hold_a   <= 4'h0;
            m_hold_b   <= 4'h0;
        end else begin
            if (m_pend_a) m_hold_a <= m_pend_data_a;
            if (m_pend_b) m_hold_b <= m_pend_data_b;
            m_pend_a <= 1'b0;
            m_pend_b <= 1'b0;
            if (clear_left > 0) begin
                model_mem[32 - clear_left] <= 4'h0;
                clear_left <= clear_left - 1;
            end else begin
                if (m_g[0]) begin
                    m_last_b <= 1'b0;
                    if (we_a) model_mem[addr_a] <= wdata_a;
                    else begin m_pend_a <= 1'b1; m_pend_data_a <= model_mem[addr_a]; end
                end
                if (m_g[1]) begin
                    m_last_b <= 1'b1;
                    if (we_b) model_mem[addr_b] <= wdata_b;
                    else begin m_pend_b <= 1'b1; m_pend_data_b <= model_mem[addr_b]; end
                end
                if (clr) clear_left <= 32;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic       e_we;
        logic [4:0] e_addr;
        logic [3:0] e_wdata;
        e_we = 1'b0; e_addr = 5'h0; e_wdata = 4'h0;
        if (clear_left > 0) begin
            e_we   = reset;
            e_addr = 5'(32 - clear_left);
        end else if (m_g[0]) begin
            e_we = we_a; e_addr = addr_a; e_wdata = wdata_a;
        end else if (m_g[1]) begin
            e_we = we_b; e_addr = addr_b; e_wdata = wdata_b;
        end
        chk("busy",      32'(busy),      32'(clear_left > 0));
        chk("gnt_a",     32'(gnt_a),     32'(m_g[0]));
        chk("gnt_b",     32'(gnt_b),     32'(m_g[1]));
        chk("ram_we",    32'(ram_we),    32'(e_we));
        chk("ram_addr",  32'(ram_addr),  32'(e_addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
        chk("rvalid_a",  32'(rvalid_a),  32'(m_pend_a));
        chk("rvalid_b",  32'(rvalid_b),  32'(m_pend_b));
        chk("rdata_a",   32'(rdata_a),   32'(m_pend_a ? m_pend_data_a : m_hold_a));
        chk("rdata_b",   32'(rdata_b),   32'(m_pend_b ? m_pend_data_b : m_hold_b));
    endtask

    task automatic check_now();
        @(negedge clk);
        compare_all();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_literal(input string tag);
        for (int i = 0; i < 32; i++) begin
            check_now();
            chk({tag, "_addr"}, 32'(ram_addr), 32'(i));
            chk({tag, "_we"},   32'(ram_we),   32'd1);
            chk({tag, "_busy"}, 32'(busy),     32'd1);
            adv();
        end
        check_now();
        chk({tag, "_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b0; clr = 1'b0;
        req_a = 1'b0; we_a = 1'b0; addr_a = 5'h0; wdata_a = 4'h0;
        req_b = 1'b0; we_b = 1'b0; addr_b = 5'h0; wdata_b = 4'h0;

        check_now();
        chk("rst_busy", 32'(busy),   32'd1);
        chk("rst_we",   32'(ram_we), 32'd0);
        adv();
        check_now();
        adv();
        reset = 1'b1;
        sweep_literal("sweep1");
        adv();

        // A reads a cleared word.
        req_a = 1'b1; we_a = 1'b0; addr_a = 5'd17;
        check_now(); chk("rd17_gnt", 32'(gnt_a), 32'd1);
        adv(); req_a = 1'b0;
        check_now(); chk("rd17_rvalid", 32'(rvalid_a), 32'd1); chk("rd17_data", 32'(rdata_a), 32'h0);
        adv();
        check_now(); chk("rd17_pulse", 32'(rvalid_a), 32'd0);
        adv();

        // Write then read-back of the same word in consecutive cycles.
        req_a = 1'b1; we_a = 1'b1; addr_a = 5'h03; wdata_a = 4'hA;
        check_now(); chk("wr3_gnt", 32'(gnt_a), 32'd1); chk("wr3_we", 32'(ram_we), 32'd1);
        adv(); we_a = 1'b0;
        check_now(); chk("rd3_gnt", 32'(gnt_a), 32'd1); chk("wr3_no_rvalid", 32'(rvalid_a), 32'd0);
        adv(); req_a = 1'b0;
        check_now(); chk("rd3_rvalid", 32'(rvalid_a), 32'd1); chk("rd3_data", 32'(rdata_a), 32'hA);
        adv();
        check_now(); chk("rd3_pulse", 32'(rvalid_a), 32'd0); chk("rd3_hold", 32'(rdata_a), 32'hA);
        adv();

        // B writes the top word, leaving last=B.
        req_b = 1'b1; we_b = 1'b1; addr_b = 5'h1F; wdata_b = 4'hF;
        check_now(); chk("wr1f_gnt", 32'(gnt_b), 32'd1);
        adv();

        // Both request for 4 cycles: A,B,A,B.
        req_a = 1'b1; we_a = 1'b0; addr_a = 5'h03;
        we_b = 1'b0; addr_b = 5'h1F;
        for (int k = 0; k < 4; k++) begin
            check_now();
            chk("rr_gnt_a", 32'(gnt_a), 32'(k % 2 == 0));
            chk("rr_gnt_b", 32'(gnt_b), 32'(k % 2 == 1));
            chk("rr_excl",  32'(gnt_a & gnt_b), 32'd0);
            if (k > 0) chk("rr_rdata_b_seen", 32'(k % 2 == 0 ? rdata_b : rdata_a),
                           32'(k % 2 == 0 ? 4'hF : 4'hA));
            adv();
        end
        req_b = 1'b0;

        // clr cycle still grants A's read; its rvalid lands in the first sweep cycle.
        clr = 1'b1;
        check_now(); chk("clr_gnt", 32'(gnt_a), 32'd1);
        adv(); clr = 1'b0; addr_a = 5'h05;
        check_now();
        chk("clr_rvalid", 32'(rvalid_a), 32'd1); chk("clr_rdata", 32'(rdata_a), 32'hA);
        chk("clr_busy", 32'(busy), 32'd1);
        adv();
        for (int i = 1; i < 32; i++) begin
            check_now(); chk("busy_no_gnt", 32'(gnt_a), 32'd0);
            adv();
        end
        check_now(); chk("first_serve_gnt", 32'(gnt_a), 32'd1);
        adv(); req_a = 1'b0;

        // Top word was cleared.
        req_b = 1'b1; we_b = 1'b0; addr_b = 5'h1F;
        check_now(); chk("rd1f_gnt", 32'(gnt_b), 32'd1);
        adv(); req_b = 1'b0;
        check_now(); chk("rd1f_rvalid", 32'(rvalid_b), 32'd1); chk("rd1f_data", 32'(rdata_b), 32'h0);
        adv();

        // Reset in the rvalid cycle of a read drops it.
        req_a = 1'b1; we_a = 1'b0; addr_a = 5'h03;
        check_now();
        adv(); req_a = 1'b0;
        chk("pre_rst_rvalid", 32'(rvalid_a), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_rvalid", 32'(rvalid_a), 32'd0);
        chk("rst_rdata",  32'(rdata_a),  32'h0);
        chk("rst_we2",    32'(ram_we),   32'd0);
        check_now();
        adv(); reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_now(); adv();
        end

        // Reset at sweep ptr=10 restarts the sweep from 0.
        check_now(); chk("ptr10_addr", 32'(ram_addr), 32'd10);
        reset = 1'b0;
        #1;
        chk("ptr10_rst_we", 32'(ram_we), 32'd0);
        chk("ptr10_rst_busy", 32'(busy), 32'd1);
        adv();
        check_now();
        adv(); reset = 1'b1;
        sweep_literal("sweep2");
        adv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
